// File: rtl/seg7_pkg.sv
// Shared encodings for the seven-segment scan driver.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
  localparam logic [6:0] GLYPH_DASH  = 7'b1000000;
  localparam logic [6:0] GLYPH_BAR   = 7'b0000110;
  localparam logic [6:0] GLYPH_F     = 7'b1110001;
  localparam logic [6:0] GLYPH_A     = 7'b1110111;
  localparam logic [6:0] GLYPH_L     = 7'b0111000;
  localparam logic [6:0] GLYPH_D     = 7'b0111111;
  localparam logic [6:0] GLYPH_U     = 7'b0111110;

  localparam logic MODE_HEX   = 1'b0;
  localparam logic MODE_GLYPH = 1'b1;

  // Standard hex font; b and d are lower-case so they differ from 8 and 0.
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to seven-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure lookup into the shared font.
  always_comb begin
    seg = hex_font(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with double-buffered content and
// optional whole-display blink.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits in
// hex mode (the rightmost digit is always shown).
//
// Handshake: load is a single-cycle strobe with no back-pressure; the driver
// always accepts it into the shadow registers and answers with a one-cycle
// load_ack on the following cycle. The shadow only reaches the display at a
// frame boundary with no load in that same cycle.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  output logic                    load_ack,
  input  logic                    mode,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [7*NUM_DIGITS-1:0] glyph,
  input  logic                    blink_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0] scan_cnt;
  logic [IW-1:0] dig_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  logic                    sh_mode, sh_blink, pending;
  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [7*NUM_DIGITS-1:0] sh_glyph;
  logic                    act_mode, act_blink;
  logic [4*NUM_DIGITS-1:0] act_value;
  logic [7*NUM_DIGITS-1:0] act_glyph;

  logic                  frame_end;
  logic                  xfer;
  logic [3:0]            cur_nib;
  logic [6:0]            cur_glyph;
  logic [6:0]            hex_seg;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] dig_next;
`ifdef LEADING_ZERO_BLANK_EN
  logic                  cur_lz;
`endif

  assign frame_end = (scan_cnt == SCAN_LAST) && (dig_idx == IDX_LAST);
  // A load on the boundary cycle wins; the transfer waits a whole frame.
  assign xfer      = frame_end && pending && !load;

  // Slot timer and digit index; the index steps when a slot expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      dig_idx  <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Shadow capture on load, shadow-to-active copy at a clean frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_mode   <= MODE_HEX;
      sh_blink  <= 1'b0;
      sh_value  <= '0;
      sh_glyph  <= '0;
      pending   <= 1'b0;
      act_mode  <= MODE_HEX;
      act_blink <= 1'b0;
      act_value <= '0;
      act_glyph <= '0;
    end else if (load) begin
      sh_mode  <= mode;
      sh_blink <= blink_en;
      sh_value <= value;
      sh_glyph <= glyph;
      pending  <= 1'b1;
    end else if (xfer) begin
      act_mode  <= sh_mode;
      act_blink <= sh_blink;
      act_value <= sh_value;
      act_glyph <= sh_glyph;
      pending   <= 1'b0;
    end
  end

  // Blink counter only runs while blink is active; clearing blink re-arms it.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (xfer && !sh_blink) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_end && act_blink) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= !blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Pick the current digit's nibble and glyph field (digit 0 is the MS field).
  always_comb begin
    cur_nib   = '0;
    cur_glyph = '0;
`ifdef LEADING_ZERO_BLANK_EN
    cur_lz    = 1'b0;
    begin : lz_scan
      logic run;
      run = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        run = run && (act_value[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
        if (dig_idx == IW'(i)) cur_lz = run && (i != NUM_DIGITS - 1);
      end
    end
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx == IW'(i)) begin
        cur_nib   = act_value[4*(NUM_DIGITS-1-i) +: 4];
        cur_glyph = act_glyph[7*(NUM_DIGITS-1-i) +: 7];
      end
    end
  end

  hex_to_seg7 u_hex (
    .nibble (cur_nib),
    .seg    (hex_seg)
  );

  // Next segment/enable values; the blink-off phase darkens everything.
  always_comb begin
    seg_next = GLYPH_BLANK;
    dig_next = '0;
    if (!(act_blink && !blink_on)) begin
      dig_next = NUM_DIGITS'(1) << dig_idx;
      if (act_mode == MODE_GLYPH) begin
        seg_next = cur_glyph;
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        seg_next = cur_lz ? GLYPH_BLANK : hex_seg;
`else
        seg_next = hex_seg;
`endif
      end
    end
  end

  // Registered outputs, one cycle behind the index.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= '0;
      dig_en     <= '0;
      frame_done <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      seg        <= seg_next;
      dig_en     <= dig_next;
      frame_done <= frame_end;
      load_ack   <= load;
    end
  end

endmodule
